// File: rtl/fp_pkg.sv
// Shared FP-array types: default format widths, packed FP word and drain FSM states.
package fp_pkg;

  localparam int W_MANTISSA_DEF  = 8;
  localparam int W_EXPONENT_DEF  = 8;
  localparam int W_FP_NUMBER_DEF = W_MANTISSA_DEF + W_EXPONENT_DEF + 1;

  typedef struct packed {
    logic                      sign;
    logic [W_EXPONENT_DEF-1:0] exponent;
    logic [W_MANTISSA_DEF-1:0] mantissa;
  } fp_word_t;

  typedef enum logic {
    DRN_IDLE,
    DRN_STREAM
  } drain_state_e;

endpackage

// File: rtl/fp_drain_shadow_buf.sv
// Shadow register array for one PE column: parallel load, indexed combinational read.
// Per-PE status flags are stored only when FP_RESULT_DRAIN_FLAGS_EN is defined.
module fp_drain_shadow_buf
  import fp_pkg::*;
#(
  parameter int W  = W_FP_NUMBER_DEF,
  parameter int N  = 4,
  localparam int WI = $clog2(N)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           load_i,
  input  logic [N*W-1:0] din_i,
`ifdef FP_RESULT_DRAIN_FLAGS_EN
  input  logic [N-1:0]   ovf_i,
  input  logic [N-1:0]   unf_i,
  input  logic [N-1:0]   exc_i,
  output logic           rd_ovf_o,
  output logic           rd_unf_o,
  output logic           rd_exc_o,
`endif
  input  logic [WI-1:0]  rd_idx_i,
  output logic [W-1:0]   rd_data_o
);

  logic [W-1:0] mem_q [N];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (load_i) begin
      for (int i = 0; i < N; i++) mem_q[i] <= din_i[i*W +: W];
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

`ifdef FP_RESULT_DRAIN_FLAGS_EN
  logic [N-1:0] ovf_q, unf_q, exc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= '0;
      unf_q <= '0;
      exc_q <= '0;
    end else if (load_i) begin
      ovf_q <= ovf_i;
      unf_q <= unf_i;
      exc_q <= exc_i;
    end
  end

  assign rd_ovf_o = ovf_q[rd_idx_i];
  assign rd_unf_o = unf_q[rd_idx_i];
  assign rd_exc_o = exc_q[rd_idx_i];
`endif

endmodule

// File: rtl/fp_result_drain.sv
// Snapshots and zeroes one PE column in a single edge, then streams the words out on valid/ready.
// FP_RESULT_DRAIN_FLAGS_EN adds per-PE ovf/unf/exc flags carried alongside each word.
module fp_result_drain
  import fp_pkg::*;
#(
  parameter int W_MANTISSA  = W_MANTISSA_DEF,
  parameter int W_EXPONENT  = W_EXPONENT_DEF,
  parameter int N_PE        = 4,
  localparam int W_FP_NUMBER = W_MANTISSA + W_EXPONENT + 1,
  localparam int W_IDX       = $clog2(N_PE)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_PE*W_FP_NUMBER-1:0] pe_x,
`ifdef FP_RESULT_DRAIN_FLAGS_EN
  input  logic [N_PE-1:0]             pe_ovf,
  input  logic [N_PE-1:0]             pe_unf,
  input  logic [N_PE-1:0]             pe_exc,
  output logic                        out_ovf,
  output logic                        out_unf,
  output logic                        out_exc,
`endif
  input  logic                        capture,
  output logic                        clear_pe,
  output logic                        busy,
  output logic [W_FP_NUMBER-1:0]      out_data,
  output logic [W_IDX-1:0]            out_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        done
);

  localparam logic [W_IDX-1:0] IDX_LAST = W_IDX'(N_PE - 1);

  drain_state_e     state_q, state_d;
  logic [W_IDX-1:0] idx_q, idx_d;
  logic             done_q, done_d;

  // Combinational so the PEs zero on the very edge the shadow buffer samples them.
  assign clear_pe = (state_q == DRN_IDLE) && capture;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      DRN_IDLE: begin
        if (capture) begin
          state_d = DRN_STREAM;
          idx_d   = '0;
        end
      end
      DRN_STREAM: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = DRN_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = DRN_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= DRN_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  fp_drain_shadow_buf #(
    .W (W_FP_NUMBER),
    .N (N_PE)
  ) u_shadow_buf (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (clear_pe),
    .din_i     (pe_x),
`ifdef FP_RESULT_DRAIN_FLAGS_EN
    .ovf_i     (pe_ovf),
    .unf_i     (pe_unf),
    .exc_i     (pe_exc),
    .rd_ovf_o  (out_ovf),
    .rd_unf_o  (out_unf),
    .rd_exc_o  (out_exc),
`endif
    .rd_idx_i  (idx_q),
    .rd_data_o (out_data)
  );

  assign out_valid = (state_q == DRN_STREAM);
  assign busy      = (state_q == DRN_STREAM);
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == IDX_LAST);
  assign done      = done_q;

endmodule

// File: tb/tb_fp_result_drain.sv
// Directed and randomized bench for fp_result_drain against a queue-based column model.
module tb_fp_result_drain;

  localparam int WM   = 8;
  localparam int WE   = 8;
  localparam int NPE  = 4;
  localparam int WFP  = WM + WE + 1;
  localparam int WIDX = $clog2(NPE);

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NPE*WFP-1:0]   pe_x;
  logic                 capture;
  logic                 clear_pe;
  logic                 busy;
  logic [WFP-1:0]       out_data;
  logic [WIDX-1:0]      out_idx;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 done;
`ifdef FP_RESULT_DRAIN_FLAGS_EN
  logic [NPE-1:0]       pe_ovf, pe_unf, pe_exc;
  logic                 out_ovf, out_unf, out_exc;
`endif

  fp_result_drain #(
    .W_MANTISSA (WM),
    .W_EXPONENT (WE),
    .N_PE       (NPE)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pe_x      (pe_x),
`ifdef FP_RESULT_DRAIN_FLAGS_EN
    .pe_ovf    (pe_ovf),
    .pe_unf    (pe_unf),
    .pe_exc    (pe_exc),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .out_exc   (out_exc),
`endif
    .capture   (capture),
    .clear_pe  (clear_pe),
    .busy      (busy),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WFP-1:0] data;
    int             idx;
    logic [2:0]     flags;
  } word_t;

  word_t exp_q[$];
  logic  done_exp;
  logic  seen_valid;
  int    n_pass;
  int    n_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, expv, $time);
  endtask

  function automatic logic [NPE*WFP-1:0] pack4(input logic [WFP-1:0] w0, input logic [WFP-1:0] w1,
                                                input logic [WFP-1:0] w2, input logic [WFP-1:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  // One cycle: apply inputs, compare against the model's pre-edge view, then advance the model.
  task automatic step(input logic cap, input logic rdy, input logic [NPE*WFP-1:0] px);
    word_t w;
    @(negedge clk);
    capture   = cap;
    out_ready = rdy;
    pe_x      = px;
    #1;
    seen_valid = out_valid;
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("busy", 32'(busy), 32'(exp_q.size() > 0));
    check("clear_pe", 32'(clear_pe), 32'(exp_q.size() == 0 && cap));
    check("done", 32'(done), 32'(done_exp));
    check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
    if (exp_q.size() > 0) begin
      check("out_data", 32'(out_data), 32'(exp_q[0].data));
      check("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
`ifdef FP_RESULT_DRAIN_FLAGS_EN
      check("out_flags", 32'({out_ovf, out_unf, out_exc}), 32'(exp_q[0].flags));
`endif
    end
    done_exp = 1'b0;
    if (exp_q.size() > 0) begin
      if (rdy) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) done_exp = 1'b1;
      end
    end else if (cap) begin
      for (int i = 0; i < NPE; i++) begin
        w.data  = px[i*WFP +: WFP];
        w.idx   = i;
        w.flags = 3'b000;
`ifdef FP_RESULT_DRAIN_FLAGS_EN
        w.flags = {pe_ovf[i], pe_unf[i], pe_exc[i]};
`endif
        exp_q.push_back(w);
      end
    end
  endtask

  function automatic logic [NPE*WFP-1:0] rand_px();
    logic [NPE*WFP-1:0] v;
    for (int i = 0; i < NPE; i++) v[i*WFP +: WFP] = WFP'($urandom);
    return v;
  endfunction

  logic [NPE*WFP-1:0] px_a, px_f;
  logic               bp_seq [7];
  int                 gaps;

  initial begin
    n_pass = 0; n_total = 0;
    done_exp = 1'b0; seen_valid = 1'b0;
    rstn = 1'b0; capture = 1'b0; out_ready = 1'b0; pe_x = '0;
`ifdef FP_RESULT_DRAIN_FLAGS_EN
    pe_ovf = '0; pe_unf = '0; pe_exc = '0;
`endif
    px_a = pack4(17'h3F80, 17'h4000, 17'h4040, 17'h4080);
    px_f = pack4(17'hFFFF, 17'hFFFF, 17'hFFFF, 17'hFFFF);
    bp_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic drain, with an exception flag on PE2 only at capture.
`ifdef FP_RESULT_DRAIN_FLAGS_EN
    pe_exc = 4'b0100;
`endif
    step(1'b1, 1'b1, px_a);
`ifdef FP_RESULT_DRAIN_FLAGS_EN
    pe_exc = 4'b0000;
`endif
    repeat (6) step(1'b0, 1'b1, px_a);

    // Backpressure
    step(1'b1, 1'b0, px_a);
    for (int i = 0; i < 7; i++) step(1'b0, bp_seq[i], px_a);
    repeat (2) step(1'b0, 1'b1, px_a);

    // Capture held while streaming; PE values change mid-stream.
    step(1'b1, 1'b1, px_a);
    step(1'b1, 1'b1, px_a);
    repeat (10) step(1'b1, 1'b1, px_f);
    repeat (6) step(1'b0, 1'b1, px_f);

    // Back-to-back: 15 cycles from idle should hold exactly 3 idle gaps.
    gaps = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, rand_px());
      if (!seen_valid) gaps++;
    end
    check("b2b_gaps", 32'(gaps), 32'd3);
    repeat (6) step(1'b0, 1'b1, px_a);

    // Reset after the 2nd transfer.
    step(1'b1, 1'b1, px_a);
    step(1'b0, 1'b1, px_a);
    step(1'b0, 1'b1, px_a);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    exp_q.delete();
    done_exp = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid_done2", 32'(done), 32'd0);
    rstn = 1'b1;
    step(1'b1, 1'b1, px_f);
    repeat (6) step(1'b0, 1'b1, px_a);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
`ifdef FP_RESULT_DRAIN_FLAGS_EN
      pe_ovf = NPE'($urandom);
      pe_unf = NPE'($urandom);
      pe_exc = NPE'($urandom);
`endif
      step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6), rand_px());
    end
    repeat (8) step(1'b0, 1'b1, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_result_drain.md
Name: fp_result_drain

Overview:
- Reader side of the FP processing-element array: snapshots the accumulated partial sums of one column of N_PE FP MAC elements in a single cycle.
- Zeroes those elements on the same clock edge as the snapshot, so no accumulation is lost or double-counted.
- Streams the captured words out one per transfer on a valid/ready interface toward the result writeback path.
- Sits between the PE column outputs and the writeback path; driven by the array sequencer.

Parameters:
- W_MANTISSA, 8, mantissa width of the FP format.
- W_EXPONENT, 8, exponent width of the FP format.
- N_PE, 4, number of PEs in the drained column (>=2).
- localparam W_FP_NUMBER = W_MANTISSA+W_EXPONENT+1.
- localparam W_IDX = $clog2(N_PE).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- pe_x  in  N_PE*W_FP_NUMBER  packed PE out_x values; PE i occupies bits [i*W_FP_NUMBER +: W_FP_NUMBER].
- capture  in  1  sequencer request to snapshot the column.
- clear_pe  out  1  combinational; drives the set_zero input of every PE in the column.
- busy  out  1  high while a stream is in progress.
- out_data  out  W_FP_NUMBER  streamed FP word.
- out_idx  out  W_IDX  PE index of out_data.
- out_valid  out  1  out_data/out_idx/out_last are valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  marks the final word (idx N_PE-1).
- done  out  1  one-cycle pulse after the last transfer.

Behaviour:
- Reset values: state IDLE; shadow buffer all zero; idx 0; out_valid 0; busy 0; done 0.
- Combinational outputs derived from this state: out_last 0, clear_pe 0.
- FSM, two states:
  - IDLE: out_valid=0, busy=0.
  - STREAM: out_valid=1, busy=1.
- clear_pe = (state==IDLE) && capture. It is combinational so the PEs zero on the same edge that the buffer samples pe_x. Zero latency, zero loss.
- IDLE with capture=1 at edge k:
  - buffer[i] <= pe_x slice i for every i.
  - idx <= 0; state <= STREAM.
  - out_valid is high from cycle k+1.
- STREAM:
  - out_data = buffer[idx]; out_idx = idx; out_last = (idx==N_PE-1).
  - A transfer occurs on an edge where out_valid && out_ready.
  - Transfer with idx<N_PE-1: idx <= idx+1.
  - Transfer with idx==N_PE-1: state <= IDLE, idx <= 0, done <= 1 for exactly one cycle.
  - out_ready low: hold out_data, out_idx and out_valid stable; never drop valid without a transfer.
  - out_valid does not depend combinationally on out_ready.
- capture while in STREAM: ignored. clear_pe stays 0 and the buffer is unchanged. The sequencer must wait for busy=0.
- capture on the same edge as the final transfer: ignored, because state is still STREAM. It is accepted on the following cycle.
- Minimum column period: N_PE+1 cycles (1 IDLE cycle + N_PE transfers).
- The buffer is only written on an accepted capture. No FP arithmetic is performed; words pass bit-exact.
- rstn asserted mid-stream: the stream is aborted immediately and all state returns to reset values. Untransferred words are discarded. No done pulse.

Optional Feature:
- Macro: FP_RESULT_DRAIN_FLAGS_EN.
- Defined:
  - Adds inputs pe_ovf, pe_unf, pe_exc (N_PE bits each), one bit per PE.
  - Adds outputs out_ovf, out_unf, out_exc (1 bit each).
  - On capture, the flag bits are sampled alongside the data into a flag buffer.
  - Each streamed word carries its PE's sampled flags, with the same stability rules as out_data.
  - Reset value of the flag buffer is 0.
- Undefined: these ports do not exist and no flag storage is built.

Decomposition:
- fp_pkg holds:
  - FP width localparam defaults.
  - typedef fp_word_t (packed sign/exponent/mantissa struct, parameterised through package constants).
  - typedef enum logic {DRN_IDLE, DRN_STREAM} drain_state_e.
- One natural sub-module: fp_drain_shadow_buf.
  - N_PE-entry register array with a parallel load enable and an indexed combinational read port.
  - Also holds the optional flag bits.
- The FSM, index counter and handshake stay in fp_result_drain.

Test Plan:
- Basic drain (N_PE=4):
  - Stimulus: pe_x = {0x3F80,0x4000,0x4040,0x4080} (bf16 1,2,3,4, PE0=0x3F80); capture pulse; out_ready=1.
  - Required: clear_pe high only in the capture cycle; 4 transfers over 4 consecutive cycles with idx 0..3 and data 0x3F80,0x4000,0x4040,0x4080; out_last only on idx 3; done one cycle after.
- Backpressure:
  - Stimulus: same words; out_ready toggles 1,0,0,1,0,1,1.
  - Required: data/idx held stable during stalls; exactly 4 transfers in order; no duplicates or drops.
- Capture while busy:
  - Stimulus: capture asserted continuously from the start; pe_x changed mid-stream to all 0xFFFF.
  - Required: clear_pe stays 0 during STREAM; original 4 words emitted; next capture accepted the cycle after the last transfer, then 0xFFFF words streamed.
- Back-to-back throughput:
  - Stimulus: capture asserted continuously with out_ready=1.
  - Required: one new stream every 5 cycles; out_valid low exactly 1 cycle between streams.
- Reset mid-stream:
  - Stimulus: rstn low after the 2nd transfer.
  - Required: out_valid, busy and done all 0 immediately; no done pulse; a clean 4-word stream follows the next capture after rstn is released.
- Flags (FP_RESULT_DRAIN_FLAGS_EN defined):
  - Stimulus: pe_exc=4'b0100 at capture, cleared the cycle after.
  - Required: out_exc=1 only on the idx 2 transfer; out_ovf and out_unf are 0 throughout.
